// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU; simple ops take one cycle, shifts/rotates/MUL iterate one bit per cycle
module alu_iter #(
  parameter int WIDTH = 8,
  parameter int CMD_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMD_W-1:0] alu_cmd,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rslt,
  output logic [WIDTH-1:0] rslt_hi,
  output logic             zero,
  output logic             carry,
  output logic             do_branch,
  output logic             bad_cmd
);
  localparam int KW = $clog2(WIDTH);
  localparam int CW = KW + 1;
  localparam logic [CMD_W-1:0] OP_ADD  = CMD_W'(5'b01000);
  localparam logic [CMD_W-1:0] OP_SUB  = CMD_W'(5'b01001);
  localparam logic [CMD_W-1:0] OP_AND  = CMD_W'(5'b01010);
  localparam logic [CMD_W-1:0] OP_OR   = CMD_W'(5'b01011);
  localparam logic [CMD_W-1:0] OP_SHL  = CMD_W'(5'b01100);
  localparam logic [CMD_W-1:0] OP_SHR  = CMD_W'(5'b01101);
  localparam logic [CMD_W-1:0] OP_ROTL = CMD_W'(5'b11110);
  localparam logic [CMD_W-1:0] OP_MOV  = CMD_W'(5'b00100);
  localparam logic [CMD_W-1:0] OP_SLT  = CMD_W'(5'b00101);
  localparam logic [CMD_W-1:0] OP_BEQ  = CMD_W'(5'b00011);
  localparam logic [CMD_W-1:0] OP_PAR  = CMD_W'(5'b01111);
  localparam logic [CMD_W-1:0] OP_MUL  = CMD_W'(5'b10010);
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
  state_t               r_state, w_next;
  logic [CMD_W-1:0]     r_cmd;
  logic [2*WIDTH-1:0]   r_op, r_acc, w_op_n, w_acc_n, w_fin;
  logic [WIDTH-1:0]     r_b, w_lo, w_res;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_rslt, r_rslt_hi;
  logic                 r_zero, r_carry, r_branch, r_bad;
  logic [KW-1:0]        w_k;
  logic [WIDTH:0]       w_sum, w_dif;
  logic                 w_accept, w_is_sh, w_is_mul, w_iter, w_last, w_c, w_br, w_bad, w_z;
  assign in_ready  = r_state == S_IDLE;
  assign out_valid = r_state == S_DONE;
  assign rslt      = r_rslt;
  assign rslt_hi   = r_rslt_hi;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign do_branch = r_branch;
  assign bad_cmd   = r_bad;
  assign w_accept  = in_valid && r_state == S_IDLE;
  assign w_k       = inB[KW-1:0];
  assign w_is_sh   = alu_cmd == OP_SHL || alu_cmd == OP_SHR || alu_cmd == OP_ROTL;
  assign w_is_mul  = alu_cmd == OP_MUL;
  assign w_iter    = w_is_mul || (w_is_sh && w_k != '0);
  assign w_last    = r_cnt == CW'(1);
  assign w_sum     = {1'b0, inA} + {1'b0, inB};
  assign w_dif     = {1'b0, inA} - {1'b0, inB};
  // Single-cycle result; a shift by zero simply passes inA through
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_br  = 1'b0;
    w_bad = 1'b0;
    case (alu_cmd)
      OP_ADD:                  {w_c, w_res} = w_sum;
      OP_SUB:                  {w_c, w_res} = w_dif;
      OP_AND:                  w_res = inA & inB;
      OP_OR:                   w_res = inA | inB;
      OP_SHL, OP_SHR, OP_ROTL: w_res = inA;
      OP_MOV:                  w_res = inB;
      OP_SLT:                  w_res = WIDTH'($signed(inA) < $signed(inB));
      OP_BEQ:                  w_br  = inA == inB;
      OP_PAR:                  w_res = WIDTH'(^inA);
      OP_MUL:                  w_res = '0;
      default:                 w_bad = 1'b1;
    endcase
    w_z = !w_bad && w_res == '0;
  end
  // One iteration step: shift/rotate the low half, or shift-add for MUL
  always_comb begin
    w_lo    = r_op[WIDTH-1:0];
    w_op_n  = r_cmd == OP_MUL ? r_op << 1 :
              r_cmd == OP_SHL ? {WIDTH'(0), w_lo << 1} :
              r_cmd == OP_SHR ? {WIDTH'(0), w_lo >> 1} :
                                {WIDTH'(0), w_lo[WIDTH-2:0], w_lo[WIDTH-1]};
    w_acc_n = r_acc + (r_b[0] ? r_op : '0);
    w_fin   = r_cmd == OP_MUL ? w_acc_n : {WIDTH'(0), w_op_n[WIDTH-1:0]};
  end
  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end
  // Next state
  always_comb begin
    w_next = r_state == S_IDLE ? (in_valid ? (w_iter ? S_ITER : S_DONE) : S_IDLE) :
             r_state == S_ITER ? (w_last ? S_DONE : S_ITER) :
                                 (out_ready ? S_IDLE : S_DONE);
  end
  // Operand capture, iteration and result/flag registers (written only on entry to DONE)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cmd     <= '0;
      r_op      <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_rslt    <= '0;
      r_rslt_hi <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_branch  <= 1'b0;
      r_bad     <= 1'b0;
    end else if (w_accept) begin
      r_cmd <= alu_cmd;
      r_op  <= {WIDTH'(0), inA};
      r_b   <= inB;
      r_acc <= '0;
      r_cnt <= w_is_mul ? CW'(WIDTH) : {1'b0, w_k};
      if (!w_iter) begin
        r_rslt    <= w_res;
        r_rslt_hi <= '0;
        r_zero    <= w_z;
        r_carry   <= w_c;
        r_branch  <= w_br;
        r_bad     <= w_bad;
      end
    end else if (r_state == S_ITER) begin
      r_op  <= w_op_n;
      r_b   <= r_b >> 1;
      r_acc <= w_acc_n;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_rslt    <= w_fin[WIDTH-1:0];
        r_rslt_hi <= w_fin[2*WIDTH-1:WIDTH];
        r_zero    <= w_fin[WIDTH-1:0] == '0;
        r_carry   <= 1'b0;
        r_branch  <= 1'b0;
        r_bad     <= 1'b0;
      end
    end
  end
endmodule
